// File: rtl/acq_hold_sampler.sv
// Acquisition/hold sampler: on each acq_clk rising edge, runs one ADC
// conversion with timeout, then holds the captured sample.
module acq_hold_sampler #(
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 2000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_clk,
  input  logic              en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_done,
  input  logic              clr_flags,
  output logic              adc_start,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          acq_q;
  logic          acq_rise;
  logic [TW-1:0] tcnt;
  logic          in_wait;
  logic          cap;
  logic          tmo;
  logic          ovr;

  assign acq_rise  = acq_clk & ~acq_q;
  assign in_wait   = (state == S_WAIT);
  assign cap       = in_wait & adc_done;
  assign tmo       = in_wait & ~adc_done & (tcnt == TMAX);
  assign adc_start = (state == S_START);
  assign busy      = (state == S_START) | in_wait;
  // Edges during a conversion are dropped, including the exit cycle.
  assign ovr       = acq_rise & busy;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == S_IDLE:  if (acq_rise && en) state_nxt = S_START;
      state == S_START: state_nxt = S_WAIT;
      state == S_WAIT:  if (cap || tmo) state_nxt = S_IDLE;
      default:          state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acq_q <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      acq_q <= acq_clk;
      if (state == S_START)
        tcnt <= '0;
      else if (in_wait && !adc_done && !tmo)
        tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      sample_cnt <= '0;
    end else begin
      hold_valid <= cap;
      if (cap) begin
        hold_data  <= adc_data;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (tmo)
        timeout_err <= 1'b1;
      else if (clr_flags)
        timeout_err <= 1'b0;
      if (ovr)
        overrun_err <= 1'b1;
      else if (clr_flags)
        overrun_err <= 1'b0;
    end
  end

endmodule
